// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory port between the instruction cache (I,
//   read-only) and the data cache (D, read/write). Only one transaction is
//   in flight at a time. Each transaction walks IDLE -> ISSUE -> WAIT -> RESP
//   and occupies the port for MEM_LAT+3 cycles. When both caches request at
//   once, round-robin arbitration alternates between them.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   i_req, i_addr            I-cache line-fill request (held until i_ack)
//   i_rdata, i_ack           returned line and one-cycle completion pulse
//   d_req, d_we, d_addr,     D-cache request: fill (d_we=0) or write-back
//   d_wdata                  (d_we=1), held until d_ack
//   d_rdata, d_ack           returned line and one-cycle completion pulse
//   mem_req, mem_we,         one-cycle strobe to memory with its fields
//   mem_addr, mem_wdata
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_req
//   busy                     high whenever the FSM is not in IDLE
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int MEM_LAT = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   logic             prio_d;
   logic             own_d;
   logic [CNT_W-1:0] cnt;
   logic             grant_d;

   // D wins when it is the only requester, or when both request and D holds priority.
   always_comb begin
      grant_d = d_req && (!i_req || prio_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prio_d    <= 1'b1;
         own_d     <= 1'b0;
         cnt       <= '0;
         i_rdata   <= '0;
         i_ack     <= 1'b0;
         d_rdata   <= '0;
         d_ack     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         // Strobes default low so every pulse lasts exactly one cycle.
         mem_req <= 1'b0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         case (state)
            // Grant and latch the winner's fields; later request changes are ignored.
            IDLE: begin
               if (i_req || d_req) begin
                  own_d     <= grant_d;
                  prio_d    <= !grant_d;
                  mem_req   <= 1'b1;
                  mem_we    <= grant_d && d_we;
                  mem_addr  <= grant_d ? d_addr : i_addr;
                  mem_wdata <= grant_d ? d_wdata : '0;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            // mem_req is high during this cycle; start the latency countdown.
            ISSUE: begin
               cnt   <= CNT_W'(MEM_LAT - 1);
               state <= WAIT;
            end
            // cnt reaches 0 on the MEM_LAT-th WAIT cycle, when mem_rdata is valid.
            WAIT: begin
               if (cnt == '0) begin
                  if (own_d) begin
                     d_rdata <= mem_rdata;
                     d_ack   <= 1'b1;
                  end else begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios plus a randomized phase for mem_arbiter. Two instances:
//   dut_a with MEM_LAT=5 and dut_b with MEM_LAT=1. Each has a small memory
//   model that presents meaningful read data only in the single cycle that is
//   MEM_LAT cycles after its mem_req, and junk in every other cycle.
module tb_mem_arbiter;
   localparam int LAT_A = 5;
   localparam int LAT_B = 1;
   localparam logic [127:0] PAT_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic         i_req, d_req, d_we, i_ack, d_ack, mem_req, mem_we, busy;
   logic [31:0]  i_addr, d_addr, mem_addr;
   logic [127:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;

   logic         i_req_b, d_req_b, d_we_b, i_ack_b, d_ack_b, mem_req_b, mem_we_b, busy_b;
   logic [31:0]  i_addr_b, d_addr_b, mem_addr_b;
   logic [127:0] d_wdata_b, i_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;

   mem_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LAT(LAT_A)) dut_a (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(rst),
      .i_req(i_req_b), .i_addr(i_addr_b), .i_rdata(i_rdata_b), .i_ack(i_ack_b),
      .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
      .d_rdata(d_rdata_b), .d_ack(d_ack_b),
      .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   // ---------------- memory models ----------------
   int           cyc = 0;
   int           req_cyc_a = -100;
   int           req_cyc_b = -100;
   logic [31:0]  req_addr_a = '0;
   logic         use_fixed = 1'b0;
   logic [127:0] fixed_line = '0;

   function automatic logic [127:0] line_fn(input logic [31:0] a, input int cy);
      return {a, ~a, 32'(cy), 32'h5A5A_C3C3};
   endfunction

   function automatic logic [127:0] junk(input int cy);
      return {4{32'hBAD0_0000 ^ 32'(cy)}};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_req) begin
         req_cyc_a  <= cyc;
         req_addr_a <= mem_addr;
      end
      if (mem_req_b) req_cyc_b <= cyc;
   end

   always_comb begin
      mem_rdata = junk(cyc);
      if (cyc == req_cyc_a + LAT_A) mem_rdata = use_fixed ? fixed_line : line_fn(req_addr_a, cyc);
      mem_rdata_b = junk(cyc);
      if (cyc == req_cyc_b + LAT_B) mem_rdata_b = PAT_B;
   end

   // ---------------- checking helpers ----------------
   int vectors = 0;
   int fails   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Records of one directed run, indexed in cycles relative to its start.
   int           n_ack, n_mreq, busy_lo, overlap, i_left, d_left;
   int           ack_cy[8];
   logic         ack_d[8];
   logic [127:0] ack_data[8];
   int           mreq_cy[8];
   logic         mreq_we[8];
   logic [31:0]  mreq_addr[8];
   logic [127:0] mreq_wd[8];

   task automatic clear_rec();
      n_ack = 0; n_mreq = 0; busy_lo = -1; overlap = 0;
      for (int j = 0; j < 8; j++) begin
         ack_cy[j] = -1; ack_d[j] = 1'b0; ack_data[j] = '0;
         mreq_cy[j] = -1; mreq_we[j] = 1'b0; mreq_addr[j] = '0; mreq_wd[j] = '0;
      end
   endtask

   // Runs dut_a for n cycles from the current cycle (cycle 0). A requester keeps
   // req high through its ack cycle, then keeps it high only if more lines remain.
   task automatic run_seq(input int n);
      bit i_drop, d_drop, was_busy;
      i_drop = 0; d_drop = 0; was_busy = 0;
      clear_rec();
      for (int k = 1; k <= n; k++) begin
         step();
         if (i_drop) begin i_req = (i_left > 0); i_drop = 0; end
         if (d_drop) begin d_req = (d_left > 0); d_drop = 0; end
         if ((i_ack && d_ack) || (mem_req && (i_ack || d_ack))) overlap++;
         if (i_ack || d_ack) begin
            if (n_ack < 8) begin
               ack_cy[n_ack]   = k;
               ack_d[n_ack]    = d_ack;
               ack_data[n_ack] = d_ack ? d_rdata : i_rdata;
            end
            n_ack++;
         end
         if (i_ack) begin i_left--; i_drop = 1; end
         if (d_ack) begin d_left--; d_drop = 1; end
         if (mem_req) begin
            if (n_mreq < 8) begin
               mreq_cy[n_mreq] = k; mreq_we[n_mreq] = mem_we;
               mreq_addr[n_mreq] = mem_addr; mreq_wd[n_mreq] = mem_wdata;
            end
            n_mreq++;
         end
         if (busy) was_busy = 1;
         else if (was_busy && busy_lo < 0) busy_lo = k;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      i_req_b = 0; i_addr_b = '0; d_req_b = 0; d_we_b = 0; d_addr_b = '0; d_wdata_b = '0;
      i_left = 0; d_left = 0; use_fixed = 1'b0;
      step();
      step();
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_i_ack", 128'(i_ack), 128'd0);
      chk("rst_d_ack", 128'(d_ack), 128'd0);
      chk("rst_mem_req", 128'(mem_req), 128'd0);
      chk("rst_mem_we", 128'(mem_we), 128'd0);
      chk("rst_mem_addr", 128'(mem_addr), 128'd0);
      chk("rst_mem_wdata", mem_wdata, 128'd0);
      chk("rst_i_rdata", i_rdata, 128'd0);
      chk("rst_d_rdata", d_rdata, 128'd0);
      chk("rst_b_busy", 128'(busy_b), 128'd0);
      chk("rst_b_acks", 128'({i_ack_b, d_ack_b, mem_req_b}), 128'd0);
      rst = 1'b0;
   endtask

   // Random-phase reference state (transaction level: grant cycle plus latched fields).
   int           c, m_free, g, i_ackc, d_ackc;
   bit           m_act, g_d, m_prio_d, i_out, d_out, i_gnt, d_gnt;
   logic         g_we, e_mreq, e_iack, e_dack, e_busy;
   logic [31:0]  g_addr;
   logic [127:0] g_wd, e_i_rd, e_d_rd, line;

   initial begin
      // ---- single I read ----
      do_reset();
      use_fixed = 1'b1; fixed_line = {4{32'hAAAA_AAAA}};
      i_req = 1; i_addr = 32'h0000_1000; i_left = 1;
      run_seq(10);
      chk("t1_mreq_cy", 128'(mreq_cy[0]), 128'd1);
      chk("t1_mem_addr", 128'(mreq_addr[0]), 128'h1000);
      chk("t1_mem_we", 128'(mreq_we[0]), 128'd0);
      chk("t1_n_ack", 128'(n_ack), 128'd1);
      chk("t1_ack_cy", 128'(ack_cy[0]), 128'd7);
      chk("t1_ack_owner", 128'(ack_d[0]), 128'd0);
      chk("t1_i_rdata", ack_data[0], {4{32'hAAAA_AAAA}});
      chk("t1_busy_lo", 128'(busy_lo), 128'd8);
      use_fixed = 1'b0;

      // ---- contention twice: D then I each time ----
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
         i_left = 1; d_left = 1;
         run_seq(20);
         chk("t2_n_ack", 128'(n_ack), 128'd2);
         chk("t2_first_owner", 128'(ack_d[0]), 128'd1);
         chk("t2_first_cy", 128'(ack_cy[0]), 128'd7);
         chk("t2_second_owner", 128'(ack_d[1]), 128'd0);
         chk("t2_second_cy", 128'(ack_cy[1]), 128'd15);
         chk("t2_overlap", 128'(overlap), 128'd0);
      end

      // ---- D write-back ----
      do_reset();
      d_req = 1; d_we = 1; d_addr = 32'h2040; d_wdata = {4{32'hDEAD_BEEF}}; d_left = 1;
      run_seq(10);
      chk("t3_mreq_cy", 128'(mreq_cy[0]), 128'd1);
      chk("t3_mem_we", 128'(mreq_we[0]), 128'd1);
      chk("t3_mem_addr", 128'(mreq_addr[0]), 128'h2040);
      chk("t3_mem_wdata", mreq_wd[0], {4{32'hDEAD_BEEF}});
      chk("t3_n_ack", 128'(n_ack), 128'd1);
      chk("t3_ack_owner", 128'(ack_d[0]), 128'd1);
      chk("t3_ack_cy", 128'(ack_cy[0]), 128'd7);

      // ---- reset during WAIT ----
      do_reset();
      i_req = 1; i_addr = 32'h3000;
      step(); step(); step();
      chk("t4_busy_cy3", 128'(busy), 128'd1);
      rst = 1'b1;
      step();
      chk("t4_busy_cy4", 128'(busy), 128'd0);
      chk("t4_strobes_cy4", 128'({i_ack, d_ack, mem_req}), 128'd0);
      rst = 1'b0; i_req = 0; i_left = 0;
      run_seq(15);
      chk("t4_no_ack", 128'(n_ack), 128'd0);
      i_req = 1; i_left = 1;
      run_seq(12);
      chk("t4_new_mreq_cy", 128'(mreq_cy[0]), 128'd1);
      chk("t4_new_addr", 128'(mreq_addr[0]), 128'h3000);
      chk("t4_new_ack_cy", 128'(ack_cy[0]), 128'd7);
      chk("t4_new_owner", 128'(ack_d[0]), 128'd0);

      // ---- three back-to-back D lines against one I line ----
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h5000; i_req = 1; i_addr = 32'h6000;
      d_left = 3; i_left = 1;
      run_seq(40);
      chk("t5_n_ack", 128'(n_ack), 128'd4);
      chk("t5_order", 128'({ack_d[0], ack_d[1], ack_d[2], ack_d[3]}), 128'b1011);
      chk("t5_ack_cy0", 128'(ack_cy[0]), 128'd7);
      chk("t5_ack_cy1", 128'(ack_cy[1]), 128'd15);
      chk("t5_ack_cy2", 128'(ack_cy[2]), 128'd23);
      chk("t5_ack_cy3", 128'(ack_cy[3]), 128'd31);
      chk("t5_n_mreq", 128'(n_mreq), 128'd4);
      chk("t5_mreq_cy3", 128'(mreq_cy[3]), 128'd25);
      chk("t5_overlap", 128'(overlap), 128'd0);

      // ---- MEM_LAT=1 instance ----
      do_reset();
      d_req_b = 1; d_we_b = 0; d_addr_b = 32'h4000;
      step();
      chk("t6_mreq_cy1", 128'(mem_req_b), 128'd1);
      chk("t6_addr_cy1", 128'(mem_addr_b), 128'h4000);
      step();
      chk("t6_mreq_cy2", 128'(mem_req_b), 128'd0);
      chk("t6_ack_cy2", 128'(d_ack_b), 128'd0);
      chk("t6_busy_cy2", 128'(busy_b), 128'd1);
      step();
      chk("t6_ack_cy3", 128'(d_ack_b), 128'd1);
      chk("t6_rdata_cy3", d_rdata_b, PAT_B);
      chk("t6_i_ack_cy3", 128'(i_ack_b), 128'd0);
      step();
      d_req_b = 0;
      chk("t6_ack_cy4", 128'(d_ack_b), 128'd0);
      chk("t6_busy_cy4", 128'(busy_b), 128'd0);

      // ---- randomized traffic on dut_a ----
      do_reset();
      m_free = cyc; m_act = 0; g = -100; m_prio_d = 1; g_d = 0; g_we = 0;
      g_addr = '0; g_wd = '0; e_i_rd = '0; e_d_rd = '0;
      i_out = 0; d_out = 0; i_gnt = 0; d_gnt = 0; i_ackc = -10; d_ackc = -10;
      for (int r = 0; r < 600; r++) begin
         c = cyc;
         if (!i_out) begin
            if (c != i_ackc) begin
               if ($urandom_range(0, 3) == 0) begin
                  i_req = 1; i_addr = $urandom() & 32'hFFFF_FFF0; i_out = 1; i_gnt = 0;
               end else i_req = 0;
            end
         end else if (i_gnt) begin
            if ($urandom_range(0, 15) == 0) i_req = 0;
            if ($urandom_range(0, 3) == 0) i_addr = $urandom();
         end
         if (!d_out) begin
            if (c != d_ackc) begin
               if ($urandom_range(0, 3) == 0) begin
                  d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom() & 32'hFFFF_FFF0;
                  d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                  d_out = 1; d_gnt = 0;
               end else d_req = 0;
            end
         end else if (d_gnt) begin
            if ($urandom_range(0, 15) == 0) d_req = 0;
            if ($urandom_range(0, 3) == 0) begin
               d_addr = $urandom(); d_we = ~d_we; d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
         end
         // Round-robin: sole requester wins; under contention D wins iff it holds priority.
         if (c >= m_free && (i_req || d_req)) begin
            g_d = d_req && (!i_req || m_prio_d);
            g = c; g_we = g_d ? d_we : 1'b0; g_addr = g_d ? d_addr : i_addr; g_wd = d_wdata;
            m_prio_d = !g_d; m_act = 1; m_free = c + LAT_A + 3;
            if (g_d) d_gnt = 1; else i_gnt = 1;
         end
         step();
         c = cyc;
         e_mreq = m_act && (c == g + 1);
         e_iack = m_act && !g_d && (c == g + LAT_A + 2);
         e_dack = m_act && g_d && (c == g + LAT_A + 2);
         e_busy = m_act && (c > g) && (c < g + LAT_A + 3);
         if (e_iack || e_dack) begin
            line = line_fn(g_addr, g + LAT_A + 1);
            if (g_d) begin e_d_rd = line; d_out = 0; d_ackc = c; end
            else begin e_i_rd = line; i_out = 0; i_ackc = c; end
         end
         chk("rnd_i_ack", 128'(i_ack), 128'(e_iack));
         chk("rnd_d_ack", 128'(d_ack), 128'(e_dack));
         chk("rnd_mem_req", 128'(mem_req), 128'(e_mreq));
         chk("rnd_busy", 128'(busy), 128'(e_busy));
         chk("rnd_i_rdata", i_rdata, e_i_rd);
         chk("rnd_d_rdata", d_rdata, e_d_rd);
         if (e_mreq) begin
            chk("rnd_mem_addr", 128'(mem_addr), 128'(g_addr));
            chk("rnd_mem_we", 128'(mem_we), 128'(g_we));
            if (g_we) chk("rnd_mem_wdata", mem_wdata, g_wd);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
